// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and data memory: queues stores, forwards the youngest
// matching entry to loads, and drains to memory whenever a load is not using the port.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_write,
    input  logic              req_read,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [PTR_W-1:0]  entry_age [DEPTH];
    logic [DEPTH-1:0]  match;
    logic              hit;
    logic [PTR_W-1:0]  best_age;
    logic [DATA_W-1:0] fwd_data;
    logic              load, load_miss, read_miss, drain, enq;

    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Age 0 is the head (oldest); an entry is valid while its age is below count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_age[gi] = PTR_W'(gi) - head_reg;
            assign match[gi] = req_read
                             && ({1'b0, entry_age[gi]} < count_reg)
                             && (addr_mem[gi] == req_addr);
        end
    endgenerate

    always_comb begin
        hit      = 1'b0;
        best_age = '0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i] && (!hit || entry_age[i] > best_age)) begin
                hit      = 1'b1;
                best_age = entry_age[i];
                fwd_data = data_mem[i];
            end
        end
    end

    // A simultaneous read+write is served as a store, but its miss still holds the port.
    assign load      = req_read & ~req_write;
    assign read_miss = req_read & ~hit;
    assign load_miss = load & ~hit;
    assign drain     = ~empty & ~read_miss;
    assign enq       = req_write & ~full;
    assign stall     = req_write & full;

    always_comb begin
        mem_read       = load_miss;
        mem_write      = drain;
        mem_address    = '0;
        mem_write_data = '0;
        load_data      = '0;
        if (load_miss) begin
            mem_address = req_addr;
        end else if (drain) begin
            mem_address    = addr_mem[head_reg];
            mem_write_data = data_mem[head_reg];
        end
        if (load) begin
            load_data = hit ? fwd_data : mem_read_data;
        end
    end

    assign count_next = count_reg + CNT_W'(enq) - CNT_W'(drain);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (drain) head_reg <= head_reg + 1'b1;
            if (enq)   tail_reg <= tail_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= req_addr;
            data_mem[tail_reg] <= req_wdata;
        end
    end

endmodule
